mesh_generator: RTL and testbench
=================================

MESH_GENERATOR -- requirements
Module: mesh_generator

Interface
REQ-001 Parameter ROWS, default 4, number of mesh rows.
REQ-002 Parameter COLUMS, default 4, number of mesh columns.
REQ-003 Parameter pckg_sz, default 40, packet width in bits.
REQ-004 Parameter fifo_depth, default 4, output FIFO depth per terminal.
REQ-005 Parameter bdcst, default {pckg_sz-18{1'b1}}, broadcast payload value.
REQ-006 The number of terminals is N = 2*ROWS+2*COLUMS; it is 16 by default.
REQ-007 clk, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-008 reset, input, 1 bit: reset is synchronous and active-low.
REQ-009 data_out_i_in[N], input, pckg_sz bits each: head packet of each external source FIFO.
REQ-010 pndng_i_in[N], input, 1 bit each: the external source holds a packet.
REQ-011 popin[N], output, 1 bit each: one-cycle pop to the external source.
REQ-012 data_out[N], output, pckg_sz bits each: head of the terminal output FIFO.
REQ-013 pndng[N], output, 1 bit each: the terminal output FIFO is non-empty.
REQ-014 pop[N], input, 1 bit each: the external sink consumes data_out.

Function
REQ-015 Packet fields are as follows:
- [pckg_sz-1:pckg_sz-8]: nxt_jump.
- [pckg_sz-9:pckg_sz-12]: target row.
- [pckg_sz-13:pckg_sz-16]: target column.
- [pckg_sz-17]: mode.
- [pckg_sz-18:0]: payload.
REQ-016 Terminals map to mesh coordinates by index i as follows:
- 0..COLUMS-1: row 0, column i+1.
- next ROWS: row i-COLUMS+1, column 0.
- next COLUMS: row ROWS+1, column i-COLUMS-ROWS+1.
- last ROWS: row i-2*COLUMS-ROWS+1, column COLUMS+1.
REQ-017 Each terminal has a one-entry input holding register.
- When the register is empty and pndng_i_in[i]=1, the block asserts popin[i] for exactly one cycle.
- The block captures data_out_i_in[i] at that same edge.
REQ-018 One global round-robin arbiter grants at most one occupied input register per cycle, starting after the last granted index.
REQ-019 On grant, a unicast packet is written to the output FIFO whose coordinates match its target row and column.
- nxt_jump is replaced by the source terminal index.
- All other bits are unchanged.
REQ-020 A granted packet whose target matches no terminal is discarded that cycle, with no output.
REQ-021 A packet targeting its own source terminal is delivered to that terminal.
REQ-022 A granted packet is skipped, and stays held, while its target FIFO is full and not popped in the same cycle.
REQ-023 Output FIFO behaviour:
- pndng[i] equals FIFO not-empty.
- data_out[i] shows the head.
- pop[i]=1 on an edge removes the head.
- pop on an empty FIFO is ignored.
REQ-024 A write into a full FIFO is accepted when pop is asserted in the same cycle.
REQ-025 Minimum latency from the popin edge to pndng high at the destination is 2 cycles.
REQ-026 Packets from one source to one destination are delivered in order.

Reset
REQ-027 With reset=0 at a clock edge, the block clears every input register and every output FIFO, and sets the arbiter pointer to 0.
REQ-028 During reset, popin and pndng are 0 and data_out is all zeros.
REQ-029 Reset mid-transfer drops all in-flight packets.

Configuration
REQ-030 Macro MESH_GENERATOR_BROADCAST_EN controls broadcast support.
- Defined: a packet whose bits [pckg_sz-19:0] equal bdcst[pckg_sz-19:0] is a broadcast.
- A broadcast is granted only when all N-1 other output FIFOs can accept it.
- It is then written to all N-1 other FIFOs in one cycle, with nxt_jump set to the source index.
- Undefined: such packets are routed as unicast by address.

Structure
REQ-031 Package mesh_generator_pkg holds the following shared items:
- field-position constants;
- the terminal-count function;
- the index-to-coordinate function;
- the packet typedef.
REQ-032 The output FIFO is the single sub-module, mesh_out_fifo, parameterized by pckg_sz and fifo_depth.

Verification
REQ-033 Reset: hold reset=0 for 5 cycles -> all pndng=0, popin=0, data_out=0.
REQ-034 Unicast: terminal 0 sends row 5, column 2, payload 0x1234 -> pndng[9] within 2+ cycles, nxt_jump=0, payload intact.
REQ-035 Backpressure:
- Stimulus: 6 packets from terminal 4 to terminal 0, with no pop.
- Response: 4 packets stored, pndng_i_in honoured only when space exists, and no loss after pops.
REQ-036 Contention: terminals 1, 2 and 3 all target terminal 8 simultaneously -> round-robin order 1, 2, 3 at the output.
REQ-037 Invalid address: target row 7, column 7 -> packet popped, no pndng anywhere.
REQ-038 Broadcast (macro defined): payload set to all-ones from terminal 5 -> all 15 other terminals show pndng with nxt_jump=5.

Source files
------------

// File: rtl/mesh_generator_pkg.sv
// Shared packet layout, terminal count and terminal-to-coordinate mapping for the mesh generator.
package mesh_generator_pkg;

    localparam int JUMP_W = 8;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 4;
    localparam int HDR_W  = JUMP_W + ROW_W + COL_W + 1;

    typedef struct packed {
        logic [JUMP_W-1:0] nxt_jump;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic              mode;
    } pkt_hdr_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } coord_t;

    function automatic int term_count(input int rows, input int cols);
        return 2 * rows + 2 * cols;
    endfunction

    // Terminals ring the mesh: top edge, left edge, bottom edge, right edge.
    function automatic coord_t term_coord(input int idx, input int rows, input int cols);
        coord_t c;
        if (idx < cols) begin
            c.row = '0;
            c.col = COL_W'(idx + 1);
        end else if (idx < cols + rows) begin
            c.row = ROW_W'(idx - cols + 1);
            c.col = '0;
        end else if (idx < 2 * cols + rows) begin
            c.row = ROW_W'(rows + 1);
            c.col = COL_W'(idx - cols - rows + 1);
        end else begin
            c.row = ROW_W'(idx - 2 * cols - rows + 1);
            c.col = COL_W'(cols + 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mesh_out_fifo.sv
// Per-terminal output FIFO; a write into a full FIFO is accepted when a pop happens in the same cycle.
module mesh_out_fifo #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_en_i,
    input  logic [pckg_sz-1:0] wr_data_i,
    input  logic               rd_en_i,
    output logic [pckg_sz-1:0] data_o,
    output logic               pndng_o,
    output logic               full_o
);
    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth + 1);

    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               do_rd, do_wr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(fifo_depth - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pndng_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CW'(fifo_depth));
    assign do_rd   = rd_en_i && pndng_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);
    assign data_o  = pndng_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr && !do_rd) cnt_d = cnt_q + CW'(1);
        if (!do_wr && do_rd) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/mesh_generator.sv
// Mesh traffic switch: one-entry input registers, one global round-robin grant per cycle, per-terminal output FIFOs.
// Broadcast delivery is enabled by defining MESH_GENERATOR_BROADCAST_EN.
module mesh_generator
    import mesh_generator_pkg::*;
#(
    parameter int                  ROWS       = 4,
    parameter int                  COLUMS     = 4,
    parameter int                  pckg_sz    = 40,
    parameter int                  fifo_depth = 4,
    parameter logic [pckg_sz-19:0] bdcst      = {(pckg_sz-18){1'b1}},
    localparam int                 N          = term_count(ROWS, COLUMS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [pckg_sz-1:0] data_out_i_in [N],
    input  logic               pndng_i_in    [N],
    output logic               popin         [N],
    output logic [pckg_sz-1:0] data_out      [N],
    output logic               pndng         [N],
    input  logic               pop           [N]
);
`ifdef MESH_GENERATOR_BROADCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       in_full_q, in_full_d;
    logic [pckg_sz-1:0] in_data_q [N];
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [N-1:0]       pin_v, pop_v, popin_v, fifo_full, can_acc;
    logic [N-1:0]       hit, is_bc, elig, wr_en;
    logic [PW-1:0]      dest [N];
    logic               grant_vld;
    logic [PW-1:0]      grant_idx, cand;
    int                 sum;
    pkt_hdr_t           out_hdr;
    logic [pckg_sz-1:0] wr_data;

    for (genvar g = 0; g < N; g++) begin : g_term
        assign pin_v[g]   = pndng_i_in[g];
        assign pop_v[g]   = pop[g];
        assign popin_v[g] = reset && !in_full_q[g] && pin_v[g];
        assign popin[g]   = popin_v[g];
        assign is_bc[g]   = BCAST_EN && (in_data_q[g][pckg_sz-19:0] == bdcst);

        mesh_out_fifo #(.pckg_sz(pckg_sz), .fifo_depth(fifo_depth)) u_fifo (
            .clk_i     (clk),
            .rst_ni    (reset),
            .wr_en_i   (wr_en[g]),
            .wr_data_i (wr_data),
            .rd_en_i   (pop_v[g]),
            .data_o    (data_out[g]),
            .pndng_o   (pndng[g]),
            .full_o    (fifo_full[g])
        );
    end

    assign can_acc = ~fifo_full | pop_v;

    // Address decode and eligibility: blocked packets stay held, unroutable ones are granted to be dropped.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            hit[i]  = 1'b0;
            dest[i] = '0;
            for (int t = 0; t < N; t++) begin
                if (term_coord(t, ROWS, COLUMS) ==
                    {in_data_q[i][pckg_sz-JUMP_W-1 -: ROW_W], in_data_q[i][pckg_sz-JUMP_W-ROW_W-1 -: COL_W]}) begin
                    hit[i]  = 1'b1;
                    dest[i] = PW'(t);
                end
            end
            if (is_bc[i])
                elig[i] = in_full_q[i] && (&(can_acc | (N'(1) << i)));
            else
                elig[i] = in_full_q[i] && (!hit[i] || can_acc[dest[i]]);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = 0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= N) sum = sum - N;
            cand = PW'(sum);
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        out_hdr          = pkt_hdr_t'(in_data_q[grant_idx][pckg_sz-1 -: HDR_W]);
        out_hdr.nxt_jump = JUMP_W'(grant_idx);
        wr_data          = {out_hdr, in_data_q[grant_idx][pckg_sz-HDR_W-1:0]};
        wr_en            = '0;
        if (grant_vld) begin
            if (is_bc[grant_idx])
                wr_en = ~(N'(1) << grant_idx);
            else if (hit[grant_idx])
                wr_en[dest[grant_idx]] = 1'b1;
        end
    end

    always_comb begin
        in_full_d = in_full_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant_vld) begin
            in_full_d[grant_idx] = 1'b0;
            rr_ptr_d             = grant_idx;
        end
        in_full_d = in_full_d | popin_v;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_full_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            in_full_q <= in_full_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (popin_v[i]) in_data_q[i] <= data_out_i_in[i];
    end

endmodule

// File: tb/tb_mesh_generator.sv
// Directed bench for mesh_generator with default parameters (4x4 mesh, 16 terminals, 40-bit packets).
module tb_mesh_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [39:0] din      [16];
    logic        pin      [16];
    logic        popin_w  [16];
    logic [39:0] dout     [16];
    logic        pndng_w  [16];
    logic        pop      [16];

    logic [39:0] src_mem [16][8];
    int          src_rd  [16];
    int          src_wr  [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mesh_generator dut (
        .clk           (clk),
        .reset         (reset),
        .data_out_i_in (din),
        .pndng_i_in    (pin),
        .popin         (popin_w),
        .data_out      (dout),
        .pndng         (pndng_w),
        .pop           (pop)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [7:0] jmp, input logic [3:0] r,
                                       input logic [3:0] c, input logic [22:0] pay);
        return {jmp, r, c, 1'b0, pay};
    endfunction

    function automatic int cnt_pndng();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(pndng_w[i]);
        return n;
    endfunction

    function automatic logic [39:0] or_dout();
        logic [39:0] acc = '0;
        for (int i = 0; i < 16; i++) acc |= dout[i];
        return acc;
    endfunction

    task automatic refresh();
        for (int i = 0; i < 16; i++) begin
            pin[i] = (src_rd[i] != src_wr[i]);
            din[i] = pin[i] ? src_mem[i][src_rd[i] % 8] : '0;
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 16; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        refresh();
    endtask

    task automatic push(input int s, input logic [39:0] p);
        src_mem[s][src_wr[s] % 8] = p;
        src_wr[s]++;
        refresh();
        #1;
    endtask

    task automatic tick();
        logic seen [16];
        for (int i = 0; i < 16; i++) seen[i] = popin_w[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            if (seen[i] && src_rd[i] != src_wr[i]) src_rd[i]++;
            pop[i] = 1'b0;
        end
        refresh();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ticks(2);
        clear_src();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int lat;
        int got_n;
        int jmp_ok;
        for (int i = 0; i < 16; i++) pop[i] = 1'b0;
        clear_src();

        // Reset with a pending source packet
        push(0, mk(8'h00, 4'd5, 4'd2, 23'h1));
        ticks(5);
        chk("rst_pndng_cnt", cnt_pndng(), 0);
        chk("rst_popin0", popin_w[0], 1'b0);
        chk("rst_src_kept", src_rd[0], 0);
        chk("rst_dout_zero", or_dout(), 40'h0);
        clear_src();
        reset = 1'b1;
        tick();

        // Unicast terminal 0 -> row 5 col 2 (terminal 9)
        push(0, mk(8'hAA, 4'd5, 4'd2, 23'h1234));
        chk("uni_popin", popin_w[0], 1'b1);
        lat = 0;
        while (lat < 10 && !pndng_w[9]) begin
            tick();
            lat++;
        end
        chk("uni_latency", lat, 2);
        chk("uni_data", dout[9], mk(8'h00, 4'd5, 4'd2, 23'h1234));
        chk("uni_only_one", cnt_pndng(), 1);
        chk("uni_popped_once", src_rd[0], 1);
        pop[9] = 1'b1;
        tick();
        chk("uni_pop_empty", pndng_w[9], 1'b0);

        // Backpressure: 6 packets terminal 4 -> terminal 0, no pops
        clear_src();
        for (int k = 1; k <= 6; k++) push(4, mk(8'h00, 4'd0, 4'd1, 23'(k)));
        ticks(20);
        chk("bp_pndng0", pndng_w[0], 1'b1);
        chk("bp_src_popped", src_rd[4], 5);
        chk("bp_popin_blocked", popin_w[4], 1'b0);
        chk("bp_src_pending", pin[4], 1'b1);
        got_n = 0;
        for (int c = 0; c < 40 && got_n < 6; c++) begin
            if (pndng_w[0]) begin
                got_n++;
                chk("bp_order", dout[0], mk(8'd4, 4'd0, 4'd1, 23'(got_n)));
                pop[0] = 1'b1;
            end
            tick();
        end
        chk("bp_received", got_n, 6);
        chk("bp_drained", cnt_pndng(), 0);

        // Contention: terminals 1,2,3 -> terminal 8 (row 5 col 1)
        do_reset();
        for (int s = 1; s <= 3; s++) src_mem[s][0] = mk(8'h00, 4'd5, 4'd1, 23'(8'h11 * s));
        for (int s = 1; s <= 3; s++) src_wr[s] = 1;
        refresh();
        #1;
        ticks(6);
        for (int s = 1; s <= 3; s++) begin
            chk("rr_order", dout[8], mk(8'(s), 4'd5, 4'd1, 23'(8'h11 * s)));
            pop[8] = 1'b1;
            tick();
        end
        chk("rr_drained", pndng_w[8], 1'b0);

        // Invalid address row 7 col 7
        clear_src();
        push(6, mk(8'h00, 4'd7, 4'd7, 23'h77));
        ticks(5);
        chk("inv_popped", src_rd[6], 1);
        chk("inv_no_pndng", cnt_pndng(), 0);

        // Self-targeted: terminal 12 is row 1 col 5
        clear_src();
        push(12, mk(8'h33, 4'd1, 4'd5, 23'h5A));
        ticks(4);
        chk("self_data", dout[12], mk(8'd12, 4'd1, 4'd5, 23'h5A));
        chk("self_only", cnt_pndng(), 1);
        pop[12] = 1'b1;
        tick();

        // All-ones payload from terminal 5
        clear_src();
`ifdef MESH_GENERATOR_BROADCAST_EN
        push(5, mk(8'h00, 4'd0, 4'd0, 23'h7FFFFF));
        ticks(4);
        chk("bc_cnt", cnt_pndng(), 15);
        chk("bc_not_self", pndng_w[5], 1'b0);
        jmp_ok = 0;
        for (int t = 0; t < 16; t++)
            if (t != 5 && dout[t] == mk(8'd5, 4'd0, 4'd0, 23'h7FFFFF)) jmp_ok++;
        chk("bc_nxt_jump", jmp_ok, 15);
        for (int t = 0; t < 16; t++) pop[t] = 1'b1;
        tick();
`else
        push(5, mk(8'h00, 4'd0, 4'd1, 23'h7FFFFF));
        ticks(4);
        chk("bc_off_cnt", cnt_pndng(), 1);
        chk("bc_off_data", dout[0], mk(8'd5, 4'd0, 4'd1, 23'h7FFFFF));
        jmp_ok = 0;
        pop[0] = 1'b1;
        tick();
`endif
        chk("bc_drained", cnt_pndng(), 0);

        // Reset mid-transfer drops the held packet
        clear_src();
        push(0, mk(8'h00, 4'd5, 4'd2, 23'h99));
        tick();
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        ticks(4);
        chk("midrst_dropped", cnt_pndng(), 0);
        chk("midrst_src", src_rd[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
